game_input_ctrl: RTL and testbench

Player-input front end and game-session controller for the Flappy Bird design. It takes the raw push-button and the bird controller's death indication. It produces the single-cycle `i_Start` and `i_Bounce` pulses that drive the bird control FSM. It sits between the board button pin and the bird controller and owns the Ready → Playing → Over session sequence, including a post-death lockout so a held or mashed button cannot instantly restart the game.

---
 rtl/game_input_ctrl_pkg.sv | 15 +
 rtl/game_input_ctrl_if.sv | 30 +++
 rtl/game_input_ctrl_debouncer.sv | 60 ++++++
 rtl/game_input_ctrl.sv | 106 ++++++++++
 tb/tb_game_input_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/game_input_ctrl_pkg.sv
// Shared session-state encoding for the game input controller, renderer and score logic.
package game_pkg;

   typedef enum logic [1:0] {
      s_Ready   = 2'd0,
      s_Playing = 2'd1,
      s_Over    = 2'd2
   } game_state_t;

   // Counter width that still works when a terminal count degenerates to a single cycle.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/game_input_ctrl_if.sv
// Button/death inputs and start/bounce/session outputs of the game input controller.
interface game_input_ctrl_if;
   import game_pkg::*;

   logic        i_Button;
   logic        i_Dead;
   logic        o_Start;
   logic        o_Bounce;
   game_state_t o_Game_State;
   logic        o_Playing;

   modport master (
      output i_Button,
      output i_Dead,
      input  o_Start,
      input  o_Bounce,
      input  o_Game_State,
      input  o_Playing
   );

   modport slave (
      input  i_Button,
      input  i_Dead,
      output o_Start,
      output o_Bounce,
      output o_Game_State,
      output o_Playing
   );

endinterface

// File: rtl/game_input_ctrl_debouncer.sv
// Button synchronizer, level debouncer and rising-edge press detector; reusable per button.
module button_debouncer
   import game_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic i_Clk,
   input  logic i_Reset,
   input  logic btn_i,
   output logic press_o,
   output logic level_o
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   sync;
   logic                   db_q;
   logic                   db_d;
   logic                   db_dly_q;
   logic [CW-1:0]          cnt_q;
   logic [CW-1:0]          cnt_d;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], btn_i};
   assign sync   = sync_q[SYNC_STAGES-1];

   // The level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_comb begin
      db_d  = db_q;
      cnt_d = '0;
      if (sync != db_q) begin
         if (cnt_q == CNT_LAST) begin
            db_d = sync;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         sync_q   <= '0;
         db_q     <= 1'b0;
         db_dly_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync_q   <= sync_d;
         db_q     <= db_d;
         db_dly_q <= db_q;
         cnt_q    <= cnt_d;
      end
   end

   assign press_o = db_q & ~db_dly_q;
   assign level_o = db_q;

endmodule

// File: rtl/game_input_ctrl.sv
// Game session controller: turns debounced presses into start/bounce pulses and
// enforces a lockout after death.
//   state     | meaning
//   s_Ready   | waiting for a press to start the game
//   s_Playing | presses flap the bird; death ends the session
//   s_Over    | lockout running; presses and deaths discarded
module game_input_ctrl
   import game_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int LOCKOUT_CYCLES  = 25000000
) (
   input  logic             i_Clk,
   input  logic             i_Reset,
   game_input_ctrl_if.slave bus
);

   localparam int LW = cnt_width(LOCKOUT_CYCLES);
   localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);

   logic          press;
   logic          btn_level;
   game_state_t   state_q;
   game_state_t   state_d;
   logic [LW-1:0] lock_q;
   logic [LW-1:0] lock_d;
   logic          start_q;
   logic          start_d;
   logic          bounce_q;
   logic          bounce_d;
   logic          playing_q;
   logic          playing_d;

   button_debouncer #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_button (
      .i_Clk  (i_Clk),
      .i_Reset(i_Reset),
      .btn_i  (bus.i_Button),
      .press_o(press),
      .level_o(btn_level)
   );

   always_comb begin
      state_d  = state_q;
      lock_d   = lock_q;
      start_d  = 1'b0;
      bounce_d = 1'b0;
      case (state_q)
         s_Ready: begin
            if (press) begin
               start_d = 1'b1;
               state_d = s_Playing;
            end
         end
         s_Playing: begin
            // Death takes priority over a coincident flap.
            if (bus.i_Dead) begin
               state_d = s_Over;
               lock_d  = LOCK_LAST;
            end else if (press) begin
               bounce_d = 1'b1;
            end
         end
         s_Over: begin
            if (lock_q == '0) begin
               state_d = s_Ready;
            end else begin
               lock_d = lock_q - LW'(1);
            end
         end
         default: begin
            state_d = s_Ready;
            lock_d  = '0;
         end
      endcase
      playing_d = (state_d == s_Playing);
   end

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         state_q   <= s_Ready;
         lock_q    <= '0;
         start_q   <= 1'b0;
         bounce_q  <= 1'b0;
         playing_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         lock_q    <= lock_d;
         start_q   <= start_d;
         bounce_q  <= bounce_d;
         playing_q <= playing_d;
      end
   end

   assign bus.o_Start      = start_q;
   assign bus.o_Bounce     = bounce_q;
   assign bus.o_Game_State = state_q;
   assign bus.o_Playing    = playing_q;

   logic unused_level;
   assign unused_level = btn_level;

endmodule

// File: tb/tb_game_input_ctrl.sv
// Directed and randomized bench for game_input_ctrl against a session-level reference model.
module tb_game_input_ctrl;
   import game_pkg::*;

   localparam int S = 2;
   localparam int D = 4;
   localparam int L = 8;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   game_input_ctrl_if bus ();

   game_input_ctrl #(
      .SYNC_STAGES    (S),
      .DEBOUNCE_CYCLES(D),
      .LOCKOUT_CYCLES (L)
   ) dut (
      .i_Clk  (clk),
      .i_Reset(rst),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: button seen S edges late; the accepted level flips once D
   // consecutive samples all disagree with it; a press is a new high level.
   bit          m_sh   [S];
   bit          m_hist [D-1];
   bit          m_db;
   bit          m_dbp;
   int          m_rem;
   game_state_t m_st;
   bit          e_start;
   bit          e_bounce;
   logic        m_press_next;

   assign m_press_next = m_db & ~m_dbp;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < S; i++) m_sh[i] <= 1'b0;
         for (int i = 0; i < D - 1; i++) m_hist[i] <= 1'b0;
         m_db     <= 1'b0;
         m_dbp    <= 1'b0;
         m_rem    <= 0;
         m_st     <= s_Ready;
         e_start  <= 1'b0;
         e_bounce <= 1'b0;
      end else begin
         automatic bit syn      = m_sh[S-1];
         automatic bit press    = m_db & ~m_dbp;
         automatic bit all_diff = (syn != m_db);
         for (int i = 0; i < D - 1; i++) if (m_hist[i] == m_db) all_diff = 1'b0;
         for (int i = S - 1; i > 0; i--) m_sh[i] <= m_sh[i-1];
         m_sh[0] <= bus.i_Button;
         for (int i = D - 2; i > 0; i--) m_hist[i] <= m_hist[i-1];
         m_hist[0] <= syn;
         m_dbp <= m_db;
         if (all_diff) m_db <= syn;
         e_start  <= 1'b0;
         e_bounce <= 1'b0;
         if (m_st == s_Ready) begin
            if (press) begin
               e_start <= 1'b1;
               m_st    <= s_Playing;
            end
         end else if (m_st == s_Playing) begin
            if (bus.i_Dead) begin
               m_st  <= s_Over;
               m_rem <= L;
            end else if (press) begin
               e_bounce <= 1'b1;
            end
         end else begin
            if (m_rem == 1) m_st <= s_Ready;
            m_rem <= m_rem - 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         chk("model_start",   8'(bus.o_Start),      8'(e_start));
         chk("model_bounce",  8'(bus.o_Bounce),     8'(e_bounce));
         chk("model_state",   8'(bus.o_Game_State), 8'(m_st));
         chk("model_playing", 8'(bus.o_Playing),    8'(m_st == s_Playing));
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_start"},   8'(bus.o_Start),      8'h0);
      chk({tag, "_bounce"},  8'(bus.o_Bounce),     8'h0);
      chk({tag, "_playing"}, 8'(bus.o_Playing),    8'h0);
      chk({tag, "_state"},   8'(bus.o_Game_State), 8'(s_Ready));
   endtask

   // Button must already be high and the next posedge is edge 1.
   task automatic start_latency(input string tag);
      for (int i = 1; i <= 9; i++) begin
         step(1);
         chk(tag, 8'(bus.o_Start), 8'(i == 7));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int found;
      int nb;
      int hold;
      checks = 0;
      errors = 0;
      rst = 1'b0;
      bus.i_Button = 1'b0;
      bus.i_Dead   = 1'b0;
      #1 rst = 1'b1;
      #1 chk_reset_vals("reset_async");
      repeat (3) begin
         step(1);
         chk("reset_hold_start", 8'(bus.o_Start), 8'h0);
      end

      // Start with button held from edge 1
      rst = 1'b0;
      bus.i_Button = 1'b1;
      start_latency("start_latency");
      chk("start_state", 8'(bus.o_Game_State), 8'(s_Playing));

      // Bounce rejection: 3-high/1-low chatter never accepted
      bus.i_Button = 1'b0;
      step(8);
      repeat (4) begin
         bus.i_Button = 1'b1;
         for (int i = 0; i < 3; i++) begin step(1); chk("chatter_bounce", 8'(bus.o_Bounce), 8'h0); end
         bus.i_Button = 1'b0;
         step(1);
         chk("chatter_bounce", 8'(bus.o_Bounce), 8'h0);
      end
      nb = 0;
      bus.i_Button = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i == 6) bus.i_Button = 1'b0;
         step(1);
         nb += int'(bus.o_Bounce);
      end
      chk("one_bounce", 8'(nb), 8'd1);
      step(8);

      // Death coincident with press
      found = 0;
      bus.i_Button = 1'b1;
      for (int i = 0; i < 20 && found == 0; i++) begin
         step(1);
         if (m_press_next) found = 1;
      end
      chk("press_found", 8'(found), 8'd1);
      bus.i_Dead = 1'b1;
      step(1);
      bus.i_Dead = 1'b0;
      chk("death_bounce",  8'(bus.o_Bounce),     8'h0);
      chk("death_state",   8'(bus.o_Game_State), 8'(s_Over));
      chk("death_playing", 8'(bus.o_Playing),    8'h0);

      // Lockout with button held throughout
      for (int j = 1; j <= 7; j++) begin
         step(1);
         chk("lockout_over", 8'(bus.o_Game_State), 8'(s_Over));
      end
      step(1);
      chk("lockout_ready", 8'(bus.o_Game_State), 8'(s_Ready));
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk("held_no_start", 8'(bus.o_Start), 8'h0);
      end
      bus.i_Button = 1'b0;
      step(8);
      bus.i_Button = 1'b1;
      start_latency("restart_latency");

      // Press inside lockout is discarded, not queued
      bus.i_Button = 1'b0;
      step(8);
      bus.i_Dead = 1'b1;
      step(1);
      bus.i_Dead = 1'b0;
      bus.i_Button = 1'b1;
      step(6);
      bus.i_Button = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk("lockout_press_start", 8'(bus.o_Start), 8'h0);
      end
      chk("lockout_press_state", 8'(bus.o_Game_State), 8'(s_Ready));

      // Stray death in Ready
      bus.i_Dead = 1'b1;
      step(1);
      bus.i_Dead = 1'b0;
      chk("stray_state",  8'(bus.o_Game_State), 8'(s_Ready));
      chk("stray_start",  8'(bus.o_Start),      8'h0);
      chk("stray_bounce", 8'(bus.o_Bounce),     8'h0);

      // Mid-cycle reset while playing, button held across release
      bus.i_Button = 1'b1;
      step(10);
      chk("pre_reset_state", 8'(bus.o_Game_State), 8'(s_Playing));
      #2 rst = 1'b1;
      #1 chk_reset_vals("reset_mid");
      repeat (3) begin
         step(1);
         chk("reset_mid_pulse", 8'(bus.o_Start | bus.o_Bounce), 8'h0);
      end
      rst = 1'b0;
      start_latency("reset_held_latency");

      // Randomized traffic against the model
      hold = 0;
      for (int c = 0; c < 1500; c++) begin
         if (hold == 0) begin
            bus.i_Button = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 8);
         end
         hold--;
         bus.i_Dead = ($urandom_range(0, 11) == 0);
         rst = ($urandom_range(0, 299) == 0);
         step(1);
      end
      rst = 1'b0;
      bus.i_Dead = 1'b0;
      step(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
